// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: captures decoded operands with optional EX/MEM and MEM/WB forwarding,
// then presents them to the ALU through an output register backed by a skid register.
// Optional feature macro: ALU_ISSUE_FWD_EN. When it is defined, forwarding is enabled.
module alu_issue_stage #(
    parameter int N    = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            inValid,
    output logic            inReady,
    input  logic [N-1:0]    inRsData,
    input  logic [N-1:0]    inRtData,
    input  logic [REGW-1:0] inRs,
    input  logic [REGW-1:0] inRt,
    input  logic [REGW-1:0] inRd,
    input  logic [15:0]     inImm,
    input  logic            inAluSrc,
    input  logic            inSignExt,
    input  logic [2:0]      inAluControl,
    input  logic            inRegWrite,
    input  logic            exmemRegWrite,
    input  logic [REGW-1:0] exmemRd,
    input  logic [N-1:0]    exmemResult,
    input  logic            memwbRegWrite,
    input  logic [REGW-1:0] memwbRd,
    input  logic [N-1:0]    memwbResult,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic [N-1:0]    a,
    output logic [N-1:0]    b,
    output logic [2:0]      aluControl,
    output logic [REGW-1:0] outRd,
    output logic            outRegWrite
);

    typedef struct packed {
        logic [N-1:0]    a;
        logic [N-1:0]    b;
        logic [2:0]      alu_control;
        logic [REGW-1:0] rd;
        logic            reg_write;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;

    logic [N-1:0] rs_fwd;
    logic [N-1:0] rt_fwd;
    logic [N-1:0] imm_ext;
    entry_t       new_entry;
    logic         accept;
    logic         issue;

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM is the younger producer, so it is tested last and wins over MEM/WB.
    function automatic logic [N-1:0] fwd_operand(
        input logic [REGW-1:0] spec,
        input logic [N-1:0]    rf_data,
        input logic            ex_we,
        input logic [REGW-1:0] ex_rd,
        input logic [N-1:0]    ex_res,
        input logic            wb_we,
        input logic [REGW-1:0] wb_rd,
        input logic [N-1:0]    wb_res
    );
        logic [N-1:0] r;
        r = rf_data;
        if (wb_we && (wb_rd == spec) && (spec != '0)) r = wb_res;
        if (ex_we && (ex_rd == spec) && (spec != '0)) r = ex_res;
        return r;
    endfunction

    assign rs_fwd = fwd_operand(inRs, inRsData, exmemRegWrite, exmemRd, exmemResult,
                                memwbRegWrite, memwbRd, memwbResult);
    assign rt_fwd = fwd_operand(inRt, inRtData, exmemRegWrite, exmemRd, exmemResult,
                                memwbRegWrite, memwbRd, memwbResult);
`else
    // Forwarding ports stay on the interface but feed nothing; this sink is never used.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{inRs, inRt, exmemRegWrite, exmemRd, exmemResult,
                                 memwbRegWrite, memwbRd, memwbResult};

    assign rs_fwd = inRsData;
    assign rt_fwd = inRtData;
`endif

    assign imm_ext = inSignExt ? N'($signed(inImm)) : N'(inImm);

    always_comb begin
        new_entry.a           = rs_fwd;
        new_entry.b           = inAluSrc ? imm_ext : rt_fwd;
        new_entry.alu_control = inAluControl;
        new_entry.rd          = inRd;
        new_entry.reg_write   = inRegWrite;
    end

    assign accept = inValid && in_ready_q;
    assign issue  = (state_q != S_EMPTY) && outReady;

    // NOTE: every variable gets its hold value before the case, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_d   = new_entry;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && issue) begin
                    out_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = S_TWO;
                end else if (issue) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (issue) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush drops the valid state only; stale data in OUT/SKID is harmless.
        if (flush) state_d = S_EMPTY;

        in_ready_d = (state_d != S_TWO);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the data registers are reset too, because the ALU-facing outputs must read 0 in reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign inReady     = in_ready_q;
    assign outValid    = (state_q != S_EMPTY);
    assign a           = out_q.a;
    assign b           = out_q.b;
    assign aluControl  = out_q.alu_control;
    assign outRd       = out_q.rd;
    assign outRegWrite = out_q.reg_write;

endmodule
